mc_rq_buffer: RTL and testbench

- Request-side elastic buffer between the phold core's memory-request port and one memory-controller (MC) port.
- Absorbs the MC's mc_rq_stall backpressure in an in-order FIFO.
- Re-issues requests and flushes to the MC with registered outputs.
- Gives the core a stall signal with guaranteed slack, so the core's request pipeline never drops a request.

---
 rtl/mc_rq_buffer_pkg.sv | 53 +++++
 rtl/mc_rq_buffer_sync_fifo.sv | 64 ++++++
 rtl/mc_rq_buffer.sv | 170 +++++++++++++++++
 tb/tb_mc_rq_buffer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_rq_buffer_pkg.sv
// mc_rq_buffer_pkg
//   Shared definitions for the core <-> memory-controller request path:
//   MC command / subcommand encodings (shared by phold and dummy_mc),
//   field widths, the request header struct and the output-slot state.
//   The rtnctl tag width is a parameter of the users, so it is kept out
//   of the header struct and appended by the module that stores entries.
package mc_rq_buffer_pkg;

  localparam int VADR_W = 48;
  localparam int DATA_W = 64;
  localparam int CMD_W  = 3;
  localparam int SCMD_W = 4;
  localparam int SIZE_W = 2;

  // MC commands
  localparam logic [CMD_W-1:0] MC_CMD_IDLE   = 3'd0;
  localparam logic [CMD_W-1:0] MC_CMD_RD     = 3'd1;
  localparam logic [CMD_W-1:0] MC_CMD_WR     = 3'd2;
  localparam logic [CMD_W-1:0] MC_CMD_ATOMIC = 3'd3;

  // MC subcommands
  localparam logic [SCMD_W-1:0] MC_SCMD_NONE    = 4'd0;
  localparam logic [SCMD_W-1:0] MC_SCMD_AMO_ADD = 4'd1;
  localparam logic [SCMD_W-1:0] MC_SCMD_AMO_XCH = 4'd2;
  localparam logic [SCMD_W-1:0] MC_SCMD_AMO_CAS = 4'd3;

  // Access sizes
  localparam logic [SIZE_W-1:0] MC_SIZE_1B = 2'd0;
  localparam logic [SIZE_W-1:0] MC_SIZE_2B = 2'd1;
  localparam logic [SIZE_W-1:0] MC_SIZE_4B = 2'd2;
  localparam logic [SIZE_W-1:0] MC_SIZE_8B = 2'd3;

  // Request header. vld is carried alongside flush so a flush-only entry
  // can be told apart from a request that also carries a flush.
  typedef struct packed {
    logic              vld;
    logic              flush;
    logic [CMD_W-1:0]  cmd;
    logic [SCMD_W-1:0] scmd;
    logic [VADR_W-1:0] vadr;
    logic [SIZE_W-1:0] size;
    logic [DATA_W-1:0] data;
  } mc_rq_hdr_t;

  localparam int HDR_W = $bits(mc_rq_hdr_t);

  // Output slot occupancy
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/mc_rq_buffer_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO, DEPTH x WIDTH. Pointers and count update on the
//   clock edge; the head entry is presented on rdata whenever not empty
//   so the consumer can load it in the same cycle it pops.
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     push, wdata  write request / data (ignored when full unless popping)
//     pop, rdata   read request / head entry (pop ignored when empty)
//     full, empty  status
//     count        entries held, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // a push into a full FIFO is fine when the head leaves the same cycle
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // storage needs no reset; pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mc_rq_buffer.sv
// mc_rq_buffer
//   Elastic request buffer between the core's memory-request port and one
//   MC port. Requests and flushes are queued in order in a FIFO and issued
//   from a registered output slot that holds while the MC stalls. The core
//   sees a registered stall early enough that STALL_SLACK more requests
//   still fit; anything beyond total capacity (DEPTH + slot) is dropped and
//   flagged on the sticky ovf_err.
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     up_rq_*           request / flush from the core, up_rq_stall back
//     mc_rq_*           request / flush to the MC, mc_rq_stall from the MC
//     occupancy         FIFO entries + slot entry, 0..DEPTH+1
//     ovf_err           set on a dropped enqueue, cleared only by reset
module mc_rq_buffer
  import mc_rq_buffer_pkg::*;
#(
  parameter int MC_RTNCTL_WIDTH = 32,
  parameter int DEPTH           = 16,
  parameter int STALL_SLACK     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       up_rq_vld,
  input  logic [CMD_W-1:0]           up_rq_cmd,
  input  logic [SCMD_W-1:0]          up_rq_scmd,
  input  logic [VADR_W-1:0]          up_rq_vadr,
  input  logic [SIZE_W-1:0]          up_rq_size,
  input  logic [MC_RTNCTL_WIDTH-1:0] up_rq_rtnctl,
  input  logic [DATA_W-1:0]          up_rq_data,
  input  logic                       up_rq_flush,
  output logic                       up_rq_stall,
  output logic                       mc_rq_vld,
  output logic [CMD_W-1:0]           mc_rq_cmd,
  output logic [SCMD_W-1:0]          mc_rq_scmd,
  output logic [VADR_W-1:0]          mc_rq_vadr,
  output logic [SIZE_W-1:0]          mc_rq_size,
  output logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  output logic [DATA_W-1:0]          mc_rq_data,
  output logic                       mc_rq_flush,
  input  logic                       mc_rq_stall,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       ovf_err
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0] STALL_TH = OCC_W'(DEPTH + 1 - STALL_SLACK);

  typedef struct packed {
    mc_rq_hdr_t                 hdr;
    logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
  } entry_t;

  entry_t           in_entry;
  entry_t           fifo_head;
  entry_t           slot_q;
  slot_state_t      state;
  slot_state_t      state_nxt;
  logic             slot_full;
  logic             slot_load;
  logic             accept;
  logic             enq;
  logic             enq_ok;
  logic             drop;
  logic             bypass;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OCC_W-1:0] fifo_count;
  logic [OCC_W-1:0] occ_next;

  // ---------------------------------------------------------------------
  // Enqueue side
  // ---------------------------------------------------------------------
  assign enq = up_rq_vld | up_rq_flush;

  always_comb begin
    in_entry            = '0;
    in_entry.hdr.vld    = up_rq_vld;
    in_entry.hdr.flush  = up_rq_flush;
    in_entry.hdr.cmd    = up_rq_cmd;
    in_entry.hdr.scmd   = up_rq_scmd;
    in_entry.hdr.vadr   = up_rq_vadr;
    in_entry.hdr.size   = up_rq_size;
    in_entry.hdr.data   = up_rq_data;
    in_entry.rtnctl     = up_rq_rtnctl;
  end

  assign slot_full = (state == SLOT_FULL);
  assign accept    = slot_full & ~mc_rq_stall;
  assign slot_load = ~slot_full | accept;

  // Whenever the FIFO holds anything the slot is full, so "FIFO full and
  // slot full" is exactly occupancy == DEPTH+1. An accept frees one place
  // in the same cycle, which makes enqueue-at-full legal then.
  assign drop      = enq & fifo_full & slot_full & ~accept;
  assign enq_ok    = enq & ~drop;
  // empty FIFO and a loadable slot: the new entry skips the FIFO
  assign bypass    = enq & fifo_empty & slot_load;
  assign fifo_pop  = slot_load & ~fifo_empty;
  assign fifo_push = enq_ok & ~bypass;

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (in_entry),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------------------------------------------------------------
  // Output slot: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= SLOT_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (slot_load) state_nxt = (!fifo_empty || enq) ? SLOT_FULL : SLOT_EMPTY;
  end

  always_comb begin
    mc_rq_vld    = accept & slot_q.hdr.vld;
    mc_rq_flush  = accept & slot_q.hdr.flush;
    mc_rq_cmd    = slot_q.hdr.cmd;
    mc_rq_scmd   = slot_q.hdr.scmd;
    mc_rq_vadr   = slot_q.hdr.vadr;
    mc_rq_size   = slot_q.hdr.size;
    mc_rq_data   = slot_q.hdr.data;
    mc_rq_rtnctl = slot_q.rtnctl;
  end

  // Slot contents: FIFO head has priority so order is preserved; the
  // incoming entry is taken only through the bypass. Contents are left
  // alone when the slot drains, the strobes already mark them invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
    end else if (slot_load) begin
      if (!fifo_empty) slot_q <= fifo_head;
      else if (enq)    slot_q <= in_entry;
    end
  end

  // ---------------------------------------------------------------------
  // Occupancy, stall threshold, overflow
  // ---------------------------------------------------------------------
  assign occupancy = fifo_count + OCC_W'(slot_full);
  assign occ_next  = occupancy + OCC_W'(enq_ok) - OCC_W'(accept);

  always_ff @(posedge clk) begin
    if (reset) begin
      up_rq_stall <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      up_rq_stall <= (occ_next >= STALL_TH);
      if (drop) ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_rq_buffer.sv
// tb_mc_rq_buffer
//   Directed scenarios with literal expectations, then randomized traffic.
//   A queue-based model (capacity DEPTH+1, head visible whenever present)
//   predicts every output and is compared on each falling edge.
module tb_mc_rq_buffer;
  import mc_rq_buffer_pkg::*;

  localparam int RW    = 32;
  localparam int DEPTH = 16;
  localparam int SLACK = 4;
  localparam int CAP   = DEPTH + 1;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          up_rq_vld = 1'b0;
  logic [2:0]    up_rq_cmd = '0;
  logic [3:0]    up_rq_scmd = '0;
  logic [47:0]   up_rq_vadr = '0;
  logic [1:0]    up_rq_size = '0;
  logic [RW-1:0] up_rq_rtnctl = '0;
  logic [63:0]   up_rq_data = '0;
  logic          up_rq_flush = 1'b0;
  logic          up_rq_stall;
  logic          mc_rq_vld;
  logic [2:0]    mc_rq_cmd;
  logic [3:0]    mc_rq_scmd;
  logic [47:0]   mc_rq_vadr;
  logic [1:0]    mc_rq_size;
  logic [RW-1:0] mc_rq_rtnctl;
  logic [63:0]   mc_rq_data;
  logic          mc_rq_flush;
  logic          mc_rq_stall = 1'b0;
  logic [OW-1:0] occupancy;
  logic          ovf_err;

  always #5 clk = ~clk;

  mc_rq_buffer #(.MC_RTNCTL_WIDTH(RW), .DEPTH(DEPTH), .STALL_SLACK(SLACK)) dut (
    .clk(clk), .reset(reset),
    .up_rq_vld(up_rq_vld), .up_rq_cmd(up_rq_cmd), .up_rq_scmd(up_rq_scmd),
    .up_rq_vadr(up_rq_vadr), .up_rq_size(up_rq_size), .up_rq_rtnctl(up_rq_rtnctl),
    .up_rq_data(up_rq_data), .up_rq_flush(up_rq_flush), .up_rq_stall(up_rq_stall),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
    .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
    .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
    .occupancy(occupancy), .ovf_err(ovf_err)
  );

  typedef struct {
    bit          v;
    bit          f;
    logic [2:0]  cmd;
    logic [3:0]  scmd;
    logic [47:0] vadr;
    logic [1:0]  size;
    logic [RW-1:0] tag;
    logic [63:0] data;
  } rq_t;

  rq_t q[$];
  bit  m_ovf   = 1'b0;
  bit  m_stall = 1'b0;
  bit  chk_en  = 1'b0;
  int  n_chk   = 0;
  int  n_err   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rq_t cur_rq();
    rq_t r;
    r.v = up_rq_vld; r.f = up_rq_flush; r.cmd = up_rq_cmd; r.scmd = up_rq_scmd;
    r.vadr = up_rq_vadr; r.size = up_rq_size; r.tag = up_rq_rtnctl; r.data = up_rq_data;
    return r;
  endfunction

  // Model: one in-order queue of everything buffered, capacity DEPTH+1.
  always @(posedge clk) begin
    rq_t tmp;
    if (reset) begin
      q.delete();
      m_ovf   = 1'b0;
      m_stall = 1'b0;
    end else begin
      if (q.size() > 0 && !mc_rq_stall) tmp = q.pop_front();
      if (up_rq_vld || up_rq_flush) begin
        if (q.size() < CAP) q.push_back(cur_rq());
        else m_ovf = 1'b1;
      end
      m_stall = (q.size() >= CAP - SLACK);
    end
  end

  always @(negedge clk) begin : cmp
    bit have;
    if (chk_en) begin
      have = (q.size() > 0);
      check("vld",   64'(mc_rq_vld),   64'(have && q[0].v && !mc_rq_stall));
      check("flush", 64'(mc_rq_flush), 64'(have && q[0].f && !mc_rq_stall));
      check("occupancy", 64'(occupancy), 64'(q.size()));
      check("up_rq_stall", 64'(up_rq_stall), 64'(m_stall));
      check("ovf_err", 64'(ovf_err), 64'(m_ovf));
      if (have) begin
        check("cmd",    64'(mc_rq_cmd),    64'(q[0].cmd));
        check("scmd",   64'(mc_rq_scmd),   64'(q[0].scmd));
        check("vadr",   64'(mc_rq_vadr),   64'(q[0].vadr));
        check("size",   64'(mc_rq_size),   64'(q[0].size));
        check("rtnctl", 64'(mc_rq_rtnctl), 64'(q[0].tag));
        check("data",   mc_rq_data,        q[0].data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    up_rq_vld   = 1'b0;
    up_rq_flush = 1'b0;
  endtask

  task automatic set_rq(input bit v, input bit f, input logic [2:0] cmd,
                        input logic [47:0] vadr, input logic [RW-1:0] tag);
    up_rq_vld    = v;
    up_rq_flush  = f;
    up_rq_cmd    = cmd;
    up_rq_scmd   = 4'($urandom_range(0, 15));
    up_rq_size   = 2'($urandom_range(0, 3));
    up_rq_vadr   = vadr;
    up_rq_rtnctl = tag;
    up_rq_data   = {$urandom(), $urandom()};
  endtask

  initial begin
    int sent;
    int slack;
    int stall_pct;
    bit ignore;
    bit fl;

    // reset state
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_occ",   64'(occupancy),   64'd0);
    check("rst_vld",   64'(mc_rq_vld),   64'd0);
    check("rst_stall", 64'(up_rq_stall), 64'd0);
    check("rst_ovf",   64'(ovf_err),     64'd0);
    check("rst_vadr",  64'(mc_rq_vadr),  64'd0);
    check("rst_tag",   64'(mc_rq_rtnctl), 64'd0);
    tick();
    reset = 1'b0;
    repeat (7) tick();

    // single read, MC free
    set_rq(1'b1, 1'b0, MC_CMD_RD, 48'h100, 32'h5);
    tick();
    idle();
    @(negedge clk);
    check("t1_vld",  64'(mc_rq_vld),    64'd1);
    check("t1_cmd",  64'(mc_rq_cmd),    64'd1);
    check("t1_vadr", 64'(mc_rq_vadr),   64'h100);
    check("t1_tag",  64'(mc_rq_rtnctl), 64'h5);
    tick();
    @(negedge clk);
    check("t1_occ0", 64'(occupancy), 64'd0);
    check("t1_vld0", 64'(mc_rq_vld), 64'd0);

    // back-to-back with MC stalled; core honours the stall with slack
    tick();
    mc_rq_stall = 1'b1;
    sent  = 0;
    slack = -1;
    for (int g = 0; g < 40 && slack != 0 && sent < 20; g++) begin
      if (up_rq_stall && slack < 0) slack = SLACK;
      set_rq(1'b1, 1'b0, MC_CMD_RD, 48'h1000 + 48'(sent), RW'(sent));
      sent++;
      if (slack > 0) slack--;
      tick();
    end
    idle();
    @(negedge clk);
    check("t2_sent",  64'(sent),        64'd17);
    check("t2_occ",   64'(occupancy),   64'd17);
    check("t2_stall", 64'(up_rq_stall), 64'd1);
    check("t2_ovf",   64'(ovf_err),     64'd0);
    tick();
    mc_rq_stall = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check("t2_vld", 64'(mc_rq_vld),    64'd1);
      check("t2_tag", 64'(mc_rq_rtnctl), 64'(i));
      tick();
    end
    @(negedge clk);
    check("t2_done", 64'(mc_rq_vld), 64'd0);
    check("t2_ovf2", 64'(ovf_err),   64'd0);

    // flush-only then write, MC stalled 3 cycles
    tick();
    mc_rq_stall = 1'b1;
    set_rq(1'b0, 1'b1, MC_CMD_IDLE, 48'h0, 32'hF0);
    tick();
    set_rq(1'b1, 1'b0, MC_CMD_WR, 48'h300, 32'hF1);
    tick();
    idle();
    @(negedge clk);
    check("t3_hold_vld", 64'(mc_rq_vld),   64'd0);
    check("t3_hold_fl",  64'(mc_rq_flush), 64'd0);
    tick();
    mc_rq_stall = 1'b0;
    @(negedge clk);
    check("t3_fl",     64'(mc_rq_flush),  64'd1);
    check("t3_fl_vld", 64'(mc_rq_vld),    64'd0);
    check("t3_fl_tag", 64'(mc_rq_rtnctl), 64'hF0);
    tick();
    @(negedge clk);
    check("t3_wr_vld", 64'(mc_rq_vld),   64'd1);
    check("t3_wr_fl",  64'(mc_rq_flush), 64'd0);
    check("t3_wr_cmd", 64'(mc_rq_cmd),   64'd2);
    tick();

    // combined request + flush
    set_rq(1'b1, 1'b1, MC_CMD_RD, 48'h200, 32'h77);
    tick();
    idle();
    @(negedge clk);
    check("t4_vld",  64'(mc_rq_vld),   64'd1);
    check("t4_fl",   64'(mc_rq_flush), 64'd1);
    check("t4_vadr", 64'(mc_rq_vadr),  64'h200);
    tick();
    @(negedge clk);
    check("t4_vld0", 64'(mc_rq_vld),   64'd0);
    check("t4_fl0",  64'(mc_rq_flush), 64'd0);

    // overflow: 18 enqueues ignoring stall
    tick();
    mc_rq_stall = 1'b1;
    for (int i = 0; i < 18; i++) begin
      set_rq(1'b1, 1'b0, MC_CMD_WR, 48'h4000 + 48'(i), 32'h100 + RW'(i));
      tick();
    end
    idle();
    @(negedge clk);
    check("t5_ovf", 64'(ovf_err),   64'd1);
    check("t5_occ", 64'(occupancy), 64'd17);
    tick();
    mc_rq_stall = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check("t5_vld", 64'(mc_rq_vld),    64'd1);
      check("t5_tag", 64'(mc_rq_rtnctl), 64'h100 + 64'(i));
      tick();
    end
    @(negedge clk);
    check("t5_done", 64'(mc_rq_vld), 64'd0);
    check("t5_ovf2", 64'(ovf_err),   64'd1);

    // reset with 8 buffered
    tick();
    mc_rq_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_rq(1'b1, 1'b0, MC_CMD_RD, 48'h5000 + 48'(i), 32'h200 + RW'(i));
      tick();
    end
    idle();
    @(negedge clk);
    check("t6_occ8", 64'(occupancy), 64'd8);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_occ",   64'(occupancy),   64'd0);
    check("t6_vld",   64'(mc_rq_vld),   64'd0);
    check("t6_stall", 64'(up_rq_stall), 64'd0);
    check("t6_ovf",   64'(ovf_err),     64'd0);
    mc_rq_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_stale", 64'(mc_rq_vld | mc_rq_flush), 64'd0);
      tick();
    end

    // randomized traffic
    stall_pct = 20;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) stall_pct = $urandom_range(0, 90);
      mc_rq_stall = ($urandom_range(0, 99) < stall_pct);
      ignore = ((c / 250) % 4 == 3);
      if (($urandom_range(0, 99) < 70) && (ignore || !up_rq_stall)) begin
        fl = ($urandom_range(0, 7) == 0);
        set_rq(fl ? 1'($urandom_range(0, 1)) : 1'b1, fl, 3'($urandom_range(0, 3)),
               48'({$urandom(), $urandom()}), RW'($urandom()));
      end else begin
        idle();
      end
      reset = ($urandom_range(0, 1499) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    mc_rq_stall = 1'b0;
    repeat (25) tick();
    @(negedge clk);
    check("drain_occ", 64'(occupancy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
